circuit_long: RTL and testbench
===============================

CIRCUIT_LONG -- requirements
Module: circuit_long

Interface
REQ-001 Parameter TRUTH_TABLE, default 8'hCA, bit {a,b,c} gives the function value for that input combination.
REQ-002 Parameter CNT_W, default 8, width of the rising-edge counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
REQ-005 a  input  1  function input, most significant truth-table index bit.
REQ-006 b  input  1  function input, middle index bit.
REQ-007 c  input  1  function input, least significant index bit.
REQ-008 f_comb  output  1  combinational function value of current a,b,c.
REQ-009 f  output  1  registered function value.
REQ-010 minterm  output  8  registered one-hot decode of {a,b,c}.
REQ-011 f_rise_cnt  output  CNT_W  saturating count of 0->1 transitions of f.

Function
REQ-012 f_comb SHALL equal TRUTH_TABLE[{a,b,c}] with zero clock latency.
REQ-013 With default TRUTH_TABLE, f_comb SHALL equal (a AND b) OR (NOT a AND c): 000->0, 001->1, 010->0, 011->1, 100->0, 101->0, 110->1, 111->1.
REQ-014 f SHALL equal the f_comb value sampled at the previous rising clk edge (latency exactly 1 cycle).
REQ-015 minterm SHALL be set at each rising edge to the one-hot vector with bit {a,b,c} set and all other bits clear.
REQ-016 f_rise_cnt SHALL increment by 1 at each edge where the registered f changes from 0 to 1 (next f = 1, current f = 0).
REQ-017 f_rise_cnt SHALL saturate at all-ones and hold; no wrap-around.
REQ-018 f falling edges and unchanged f SHALL leave f_rise_cnt unchanged.
REQ-019 Inputs SHALL be treated as synchronous to clk; no internal synchronizers.
REQ-020 No X propagation from valid 0/1 inputs; every input combination SHALL produce a defined output.

Reset
REQ-021 While rst_n is low, f SHALL be 0, minterm SHALL be 8'h00, f_rise_cnt SHALL be 0, regardless of clk.
REQ-022 Reset assertion SHALL take effect immediately, without waiting for a clock edge, including mid-operation.
REQ-023 f_comb SHALL remain purely combinational and unaffected by rst_n.
REQ-024 After rst_n deasserts, the first rising edge SHALL load f and minterm from current inputs; a 0->1 step of f on that edge SHALL count as a rise.

Verification
REQ-025 Exhaustive sweep of all 8 {a,b,c} values, one per cycle -> f_comb matches REQ-013 immediately; f matches one cycle later; minterm = 1<<{a,b,c}.
REQ-026 Sequence abc = 000,001,000,001,000 after reset -> f = 0,1,0,1,0 and f_rise_cnt = 2.
REQ-027 Hold abc = 111 for 10 cycles after reset -> f = 1, f_rise_cnt = 1 (single rise only).
REQ-028 Toggle abc between 000 and 011 for 600 cycles with CNT_W = 8 -> f_rise_cnt stops at 8'hFF.
REQ-029 Assert rst_n low between clock edges with f = 1, f_rise_cnt = 5 -> f, minterm, f_rise_cnt go to 0 before next edge; f_comb still tracks inputs.
REQ-030 TRUTH_TABLE = 8'h96 override, sweep all inputs -> f_comb = a XOR b XOR c.

Source files
------------

// File: rtl/circuit_long.sv
// circuit_long: 3-input lookup function with registered value,
// one-hot minterm decode and a saturating rising-edge counter.
module circuit_long #(
    parameter logic [7:0] TRUTH_TABLE = 8'hCA,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             f_comb,
    output logic             f,
    output logic [7:0]       minterm,
    output logic [CNT_W-1:0] f_rise_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       idx;
    logic [7:0]       minterm_nxt;
    logic             rise;
    logic [CNT_W-1:0] cnt_nxt;

    assign idx    = {a, b, c};
    assign f_comb = TRUTH_TABLE[idx];

    // One-hot decode of the current input combination.
    always_comb begin
        minterm_nxt      = 8'h00;
        minterm_nxt[idx] = 1'b1;
    end

    // Next counter value: bump on a 0->1 step of f, stick at all-ones.
    always_comb begin
        rise    = f_comb & ~f;
        cnt_nxt = f_rise_cnt;
        if (rise && (f_rise_cnt != CNT_MAX)) begin
            cnt_nxt = f_rise_cnt + 1'b1;
        end
    end

    // State registers; reset clears them without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f          <= 1'b0;
            minterm    <= 8'h00;
            f_rise_cnt <= '0;
        end else begin
            f          <= f_comb;
            minterm    <= minterm_nxt;
            f_rise_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_circuit_long.sv
// tb_circuit_long: directed checks of circuit_long with the default
// table and an XOR-3 override instance sharing the same inputs.
module tb_circuit_long;

    logic       clk;
    logic       rst_n;
    logic       a, b, c;
    logic       f_comb, f;
    logic [7:0] minterm;
    logic [7:0] f_rise_cnt;
    logic       x_f_comb, x_f;
    logic [7:0] x_minterm;
    logic [7:0] x_f_rise_cnt;

    int vectors;
    int miscompares;

    logic       m_f;
    logic [7:0] m_cnt;

    circuit_long #(.TRUTH_TABLE(8'hCA), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .f_comb(f_comb), .f(f), .minterm(minterm),
        .f_rise_cnt(f_rise_cnt)
    );

    circuit_long #(.TRUTH_TABLE(8'h96), .CNT_W(8)) dut_xor (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .f_comb(x_f_comb), .f(x_f), .minterm(x_minterm),
        .f_rise_cnt(x_f_rise_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fca(input logic [2:0] v);
        return (v[2] & v[1]) | (~v[2] & v[0]);
    endfunction

    function automatic logic f96(input logic [2:0] v);
        return v[2] ^ v[1] ^ v[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {a, b, c} = 3'b000;
        m_f   = 1'b0;
        m_cnt = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [2:0] v);
        logic nf;
        @(negedge clk);
        {a, b, c} = v;
        #1;
        chk("f_comb", f_comb, fca(v));
        @(posedge clk);
        #1;
        nf = fca(v);
        if (nf && !m_f && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        m_f = nf;
        chk("f", f, m_f);
        chk("minterm", minterm, 32'd1 << v);
        chk("f_rise_cnt", f_rise_cnt, m_cnt);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_f         = 1'b0;
        m_cnt       = 8'h00;
        rst_n       = 1'b0;
        {a, b, c}   = 3'b111;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_f", f, 1'b0);
        chk("rst_minterm", minterm, 8'h00);
        chk("rst_cnt", f_rise_cnt, 8'h00);
        chk("rst_f_comb_111", f_comb, 1'b1);
        {a, b, c} = 3'b100;
        #1;
        chk("rst_f_comb_100", f_comb, 1'b0);

        // exhaustive sweep, both tables
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a, b, c} = 3'(i);
            #1;
            chk("sweep_f_comb", f_comb, fca(3'(i)));
            chk("xor_f_comb", x_f_comb, f96(3'(i)));
            @(posedge clk);
            #1;
            chk("sweep_f", f, fca(3'(i)));
            chk("sweep_minterm", minterm, 32'd1 << i);
            chk("xor_f", x_f, f96(3'(i)));
        end
        chk("sweep_cnt", f_rise_cnt, 8'd3);

        // 000,001,000,001,000
        do_reset();
        step(3'b000);
        step(3'b001);
        step(3'b000);
        step(3'b001);
        step(3'b000);
        chk("seq_f", f, 1'b0);
        chk("seq_cnt", f_rise_cnt, 8'd2);

        // hold 111 for 10 cycles
        do_reset();
        for (int i = 0; i < 10; i++) step(3'b111);
        chk("hold_f", f, 1'b1);
        chk("hold_cnt", f_rise_cnt, 8'd1);

        // saturation
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            step(3'b011);
            step(3'b000);
            if (k == 254) chk("sat_254", f_rise_cnt, 8'hFE);
            if (k == 255) chk("sat_255", f_rise_cnt, 8'hFF);
        end
        chk("sat_end", f_rise_cnt, 8'hFF);

        // async reset mid-operation
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(3'b011);
            step(3'b000);
        end
        step(3'b011);
        chk("pre_f", f, 1'b1);
        chk("pre_cnt", f_rise_cnt, 8'd5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_f", f, 1'b0);
        chk("async_minterm", minterm, 8'h00);
        chk("async_cnt", f_rise_cnt, 8'h00);
        {a, b, c} = 3'b110;
        #1;
        chk("async_f_comb_110", f_comb, 1'b1);
        {a, b, c} = 3'b010;
        #1;
        chk("async_f_comb_010", f_comb, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
